// File: rtl/sdram_traffic_master_if.sv
// sdram_traffic_master_if: user-side write/read port bundle between a traffic
// initiator and the sdram_mcb controller, in the clk_rw domain.
//   write port : wr_load, wr_addr, wr_length, wr_req, din  (initiator -> mcb)
//                wr_done, wr_rdy                          (mcb -> initiator)
//   read port  : rd_load, rd_addr, rd_length, rd_req      (initiator -> mcb)
//                dout, rd_done, rd_fifo_empty             (mcb -> initiator)
// Modports: master = initiator side, slave = controller side.
interface sdram_traffic_master_if;
  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;

  logic              wr_load;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] wr_length;
  logic              wr_req;
  logic [DATA_W-1:0] din;
  logic              wr_done;
  logic              wr_rdy;

  logic              rd_load;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_length;
  logic              rd_req;
  logic [DATA_W-1:0] dout;
  logic              rd_done;
  logic              rd_fifo_empty;

  modport master (
    output wr_load, wr_addr, wr_length, wr_req, din,
    input  wr_done, wr_rdy,
    output rd_load, rd_addr, rd_length, rd_req,
    input  dout, rd_done, rd_fifo_empty
  );

  modport slave (
    input  wr_load, wr_addr, wr_length, wr_req, din,
    output wr_done, wr_rdy,
    input  rd_load, rd_addr, rd_length, rd_req,
    output dout, rd_done, rd_fifo_empty
  );
endinterface

// File: rtl/sdram_traffic_master.sv
// sdram_traffic_master: on-board write/read-back/compare initiator for the
// sdram_mcb user interface. Writes `length` pattern words from `base_addr`,
// waits for wr_done, reads the range back and counts miscompares.
// Ports:
//   clk_rw, rst_n          clock, asynchronous active-low reset
//   start_i                one-cycle run request (sampled in IDLE only)
//   base_addr_i, length_i  run range, latched on start
//   seed_i, mode_i         pattern seed / select (0 = increment, 1 = LFSR)
//   busy_o, done_o         run in progress / one-cycle end-of-run pulse
//   pass_o, err_cnt_o      result flag and saturating miscompare count
//   first_err_addr_o       address of the first miscompare (0 if none)
//   mcb                    write/read port bundle to sdram_mcb
module sdram_traffic_master #(
  parameter int unsigned ERR_W = 16
) (
  input  logic                      clk_rw,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [23:0]               base_addr_i,
  input  logic [23:0]               length_i,
  input  logic [15:0]               seed_i,
  input  logic                      mode_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic [ERR_W-1:0]          err_cnt_o,
  output logic [23:0]               first_err_addr_o,
  sdram_traffic_master_if.master    mcb
);

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LOAD,
    S_WR_DATA,
    S_WR_WAIT,
    S_RD_LOAD,
    S_RD_DATA,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [ADDR_W-1:0]   req_cnt_q, req_cnt_d;
  logic [ADDR_W-1:0]   chk_cnt_q, chk_cnt_d;
  logic [DATA_W-1:0]   wr_pat_q, wr_pat_d;
  logic [DATA_W-1:0]   rd_pat_q, rd_pat_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   first_err_q, first_err_d;
  logic                pass_q, pass_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                wr_load_q, wr_load_d;
  logic                rd_load_q, rd_load_d;
  logic                rd_req_d_q;
  logic                wr_req_c;
  logic                rd_req_c;
  logic                rd_done_unused;

  // rd_done carries no sequencing information for this block.
  assign rd_done_unused = mcb.rd_done;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1 (right-shift form), or +1 increment.
  function automatic logic [DATA_W-1:0] pat_next(input logic [DATA_W-1:0] p,
                                                 input logic              m);
    if (m) begin
      pat_next = {p[0] ^ p[2] ^ p[3] ^ p[5], p[DATA_W-1:1]};
    end else begin
      pat_next = p + DATA_W'(1);
    end
  endfunction

  // An all-zero LFSR state would lock up, so a zero seed starts at 1.
  function automatic logic [DATA_W-1:0] pat_init(input logic [DATA_W-1:0] s,
                                                 input logic              m);
    if (m && (s == '0)) begin
      pat_init = DATA_W'(1);
    end else begin
      pat_init = s;
    end
  endfunction

  // State, latched parameters, counters and registered outputs.
  always_ff @(posedge clk_rw or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      mode_q      <= 1'b0;
      wr_cnt_q    <= '0;
      req_cnt_q   <= '0;
      chk_cnt_q   <= '0;
      wr_pat_q    <= '0;
      rd_pat_q    <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_load_q   <= 1'b0;
      rd_load_q   <= 1'b0;
      rd_req_d_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      mode_q      <= mode_d;
      wr_cnt_q    <= wr_cnt_d;
      req_cnt_q   <= req_cnt_d;
      chk_cnt_q   <= chk_cnt_d;
      wr_pat_q    <= wr_pat_d;
      rd_pat_q    <= rd_pat_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_load_q   <= wr_load_d;
      rd_load_q   <= rd_load_d;
      rd_req_d_q  <= rd_req_c;
    end
  end

  // Next-state, datapath and strobe decode.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    mode_d      = mode_q;
    wr_cnt_d    = wr_cnt_q;
    req_cnt_d   = req_cnt_q;
    chk_cnt_d   = chk_cnt_q;
    wr_pat_d    = wr_pat_q;
    rd_pat_d    = rd_pat_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;
    wr_req_c    = 1'b0;
    rd_req_c    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          base_d      = base_addr_i;
          len_d       = length_i;
          mode_d      = mode_i;
          wr_pat_d    = pat_init(seed_i, mode_i);
          rd_pat_d    = pat_init(seed_i, mode_i);
          wr_cnt_d    = '0;
          req_cnt_d   = '0;
          chk_cnt_d   = '0;
          err_cnt_d   = '0;
          first_err_d = '0;
          pass_d      = 1'b0;
          state_d     = (length_i == '0) ? S_DONE : S_WR_LOAD;
        end
      end
      S_WR_LOAD: state_d = S_WR_DATA;
      S_WR_DATA: begin
        wr_req_c = mcb.wr_rdy && (wr_cnt_q < len_q);
        if (wr_req_c) begin
          wr_cnt_d = wr_cnt_q + ADDR_W'(1);
          wr_pat_d = pat_next(wr_pat_q, mode_q);
        end
        if (wr_cnt_d == len_q) state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (mcb.wr_done) state_d = S_RD_LOAD;
      end
      S_RD_LOAD: state_d = S_RD_DATA;
      S_RD_DATA: begin
        rd_req_c = !mcb.rd_fifo_empty && (req_cnt_q < len_q);
        if (rd_req_c) req_cnt_d = req_cnt_q + ADDR_W'(1);
        // dout belongs to the rd_req issued one cycle earlier.
        if (rd_req_d_q) begin
          rd_pat_d  = pat_next(rd_pat_q, mode_q);
          chk_cnt_d = chk_cnt_q + ADDR_W'(1);
          if (mcb.dout != rd_pat_q) begin
            // err_cnt saturates and never wraps, so zero means no prior error.
            if (err_cnt_q == '0) first_err_d = base_q + chk_cnt_q;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
          end
        end
        if (chk_cnt_d == len_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_DONE) pass_d = (err_cnt_d == '0);

    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
    wr_load_d = (state_d == S_WR_LOAD);
    rd_load_d = (state_d == S_RD_LOAD);
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign pass_o           = pass_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;

  assign mcb.wr_load   = wr_load_q;
  assign mcb.wr_addr   = base_q;
  assign mcb.wr_length = len_q;
  assign mcb.wr_req    = wr_req_c;
  assign mcb.din       = wr_pat_q;
  assign mcb.rd_load   = rd_load_q;
  assign mcb.rd_addr   = base_q;
  assign mcb.rd_length = len_q;
  assign mcb.rd_req    = rd_req_c;

endmodule

// File: tb/tb_sdram_traffic_master.sv
// tb_sdram_traffic_master: table-driven bench for sdram_traffic_master with a
// behavioural sdram_mcb port model (word store, stall/empty shaping, read
// corruption) and hand-written reset / restart sequences.
`timescale 1ns/1ps
module tb_sdram_traffic_master;

  localparam int unsigned ERR_W = 16;

  logic             clk_rw = 1'b0;
  logic             rst_n;
  logic             start;
  logic [23:0]      base_addr;
  logic [23:0]      length;
  logic [15:0]      seed;
  logic             mode;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [23:0]      first_err_addr;

  sdram_traffic_master_if bus();

  sdram_traffic_master #(.ERR_W(ERR_W)) dut (
    .clk_rw           (clk_rw),
    .rst_n            (rst_n),
    .start_i          (start),
    .base_addr_i      (base_addr),
    .length_i         (length),
    .seed_i           (seed),
    .mode_i           (mode),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass),
    .err_cnt_o        (err_cnt),
    .first_err_addr_o (first_err_addr),
    .mcb              (bus)
  );

  always #5 clk_rw = ~clk_rw;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- port model configuration (written by the main thread) ----
  int stall_at     = -1;
  int stall_len    = 0;
  bit toggle_empty = 1'b0;
  int cor_a        = -1;
  int cor_b        = -1;

  // ---------------- port model state (written by the model only) -------------
  logic [15:0] mem [1024];
  int  tot_writes = 0;
  int  tot_reads  = 0;
  int  wr_loads   = 0;
  int  rd_loads   = 0;
  int  din_viol   = 0;

  // Model of the sdram_mcb user port; inputs change on the falling edge and
  // DUT strobes are sampled 1 ns later, well before the next rising edge.
  initial begin : port_model
    int  wcnt, wlen, rcnt, stall_left, done_dly, pend_idx;
    bit  wr_phase, rd_pend, have_prev, prev_req;
    logic [15:0] prev_din;
    wcnt = 0; wlen = 0; rcnt = 0; stall_left = 0; done_dly = 0; pend_idx = 0;
    wr_phase = 0; rd_pend = 0; have_prev = 0; prev_req = 0; prev_din = '0;
    bus.wr_done = 1'b0; bus.wr_rdy = 1'b1; bus.dout = '0;
    bus.rd_done = 1'b0; bus.rd_fifo_empty = 1'b0;
    forever begin
      @(negedge clk_rw);
      if (!rst_n) begin
        rd_pend = 0; done_dly = 0; wr_phase = 0; stall_left = 0;
        bus.wr_done = 1'b0; bus.wr_rdy = 1'b1; bus.rd_fifo_empty = 1'b0;
      end else begin
        if (rd_pend) begin
          bus.dout = mem[pend_idx % 1024] ^
                     (((pend_idx == cor_a) || (pend_idx == cor_b)) ? 16'h0100 : 16'h0000);
          rd_pend = 0;
        end
        bus.wr_done = 1'b0;
        if (done_dly > 0) begin
          done_dly--;
          if (done_dly == 0) bus.wr_done = 1'b1;
        end
        if ((stall_left > 0) && (wcnt == stall_at)) begin
          bus.wr_rdy = 1'b0;
          stall_left--;
        end else begin
          bus.wr_rdy = 1'b1;
        end
        bus.rd_fifo_empty = toggle_empty ? ~bus.rd_fifo_empty : 1'b0;
        #1;
        if (bus.wr_load) begin
          wr_loads++;
          wlen = int'(bus.wr_length);
          wcnt = 0; wr_phase = 1; have_prev = 0; stall_left = stall_len;
        end
        if (bus.rd_load) begin
          rd_loads++;
          rcnt = 0;
        end
        if (wr_phase) begin
          if (have_prev && !prev_req && (bus.din !== prev_din)) din_viol++;
          prev_req = bus.wr_req; prev_din = bus.din; have_prev = 1;
        end
        if (bus.wr_req) begin
          mem[wcnt % 1024] = bus.din;
          wcnt++; tot_writes++;
          if (wcnt == wlen) begin
            wr_phase = 0;
            done_dly = 3;
          end
        end
        if (bus.rd_req) begin
          rd_pend = 1; pend_idx = rcnt;
          rcnt++; tot_reads++;
        end
      end
    end
  end

  // ---------------- helpers ---------------------------------------------------
  task automatic check_reset_outputs(input string p);
    check({p, "_busy"},      32'(busy), 0);
    check({p, "_done"},      32'(done), 0);
    check({p, "_pass"},      32'(pass), 0);
    check({p, "_err_cnt"},   32'(err_cnt), 0);
    check({p, "_first_err"}, 32'(first_err_addr), 0);
    check({p, "_wr_load"},   32'(bus.wr_load), 0);
    check({p, "_wr_req"},    32'(bus.wr_req), 0);
    check({p, "_rd_load"},   32'(bus.rd_load), 0);
    check({p, "_rd_req"},    32'(bus.rd_req), 0);
    check({p, "_wr_addr"},   32'(bus.wr_addr), 0);
    check({p, "_wr_length"}, 32'(bus.wr_length), 0);
    check({p, "_rd_addr"},   32'(bus.rd_addr), 0);
    check({p, "_rd_length"}, 32'(bus.rd_length), 0);
    check({p, "_din"},       32'(bus.din), 0);
  endtask

  // Presents start for one cycle; returns on the falling edge after acceptance.
  task automatic launch(input logic [23:0] b, input logic [23:0] l,
                        input logic [15:0] s, input logic m);
    @(negedge clk_rw);
    base_addr = b; length = l; seed = s; mode = m; start = 1'b1;
    @(negedge clk_rw);
    start = 1'b0;
  endtask

  task automatic wait_done(input string p);
    int n;
    n = 0;
    while (!done && (n < 20000)) begin
      @(negedge clk_rw);
      n++;
    end
    check({p, "_done_seen"}, 32'(done), 1);
  endtask

  function automatic int pattern_mismatches(input int len, input logic [15:0] s, input logic m);
    logic [15:0] e;
    int mism;
    e = (m && (s == 16'h0000)) ? 16'h0001 : s;
    mism = 0;
    for (int k = 0; k < len; k++) begin
      if (mem[k] !== e) mism++;
      e = m ? {^(e & 16'h002D), e[15:1]} : (e + 16'd1);
    end
    return mism;
  endfunction

  typedef struct {
    logic [23:0] base;
    logic [23:0] len;
    logic [15:0] seed;
    logic        mode;
    int          st_at;
    int          st_len;
    bit          toggle;
    int          ca;
    int          cb;
    logic        exp_pass;
    logic [15:0] exp_err;
    logic [23:0] exp_first;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int w0, r0, wl0, rl0, dv0;
    string p;

    vecs[0] = '{24'h0001F0, 24'd1024,  16'h0000, 1'b0, -1, 0,  1'b0, -1, -1, 1'b1, 16'd0, 24'h000000};
    vecs[1] = '{24'h0001F1, 24'h000100, 16'hACE1, 1'b1, -1, 0,  1'b0, -1, -1, 1'b1, 16'd0, 24'h000000};
    vecs[2] = '{24'h000100, 24'd16,    16'h1234, 1'b0, -1, 0,  1'b0,  5,  9, 1'b0, 16'd2, 24'h000105};
    vecs[3] = '{24'h000200, 24'd40,    16'h0000, 1'b1,  7, 10, 1'b1, -1, -1, 1'b1, 16'd0, 24'h000000};
    vecs[4] = '{24'h000123, 24'd0,     16'h7777, 1'b0, -1, 0,  1'b0, -1, -1, 1'b1, 16'd0, 24'h000000};
    vecs[5] = '{24'hFFFFFE, 24'd8,     16'hFFFE, 1'b0, -1, 0,  1'b1,  3, -1, 1'b0, 16'd1, 24'h000001};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; seed = '0; mode = 1'b0;
    repeat (3) @(negedge clk_rw);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk_rw);

    for (int i = 0; i < 6; i++) begin
      p = $sformatf("v%0d", i);
      stall_at = vecs[i].st_at; stall_len = vecs[i].st_len;
      toggle_empty = vecs[i].toggle; cor_a = vecs[i].ca; cor_b = vecs[i].cb;
      w0 = tot_writes; r0 = tot_reads; wl0 = wr_loads; rl0 = rd_loads; dv0 = din_viol;
      launch(vecs[i].base, vecs[i].len, vecs[i].seed, vecs[i].mode);
      if (vecs[i].len != 0) begin
        check({p, "_busy_t1"},    32'(busy), 1);
        check({p, "_wr_load_t1"}, 32'(bus.wr_load), 1);
      end else begin
        check({p, "_done_t1"},    32'(done), 1);
        check({p, "_busy_t1"},    32'(busy), 0);
      end
      wait_done(p);
      check({p, "_busy_at_done"}, 32'(busy), 0);
      check({p, "_pass"},      32'(pass), 32'(vecs[i].exp_pass));
      check({p, "_err_cnt"},   32'(err_cnt), 32'(vecs[i].exp_err));
      check({p, "_first_err"}, 32'(first_err_addr), 32'(vecs[i].exp_first));
      check({p, "_writes"},    32'(tot_writes - w0), 32'(vecs[i].len));
      check({p, "_reads"},     32'(tot_reads - r0), 32'(vecs[i].len));
      check({p, "_wr_loads"},  32'(wr_loads - wl0), (vecs[i].len != 0) ? 32'd1 : 32'd0);
      check({p, "_rd_loads"},  32'(rd_loads - rl0), (vecs[i].len != 0) ? 32'd1 : 32'd0);
      check({p, "_din_stall"}, 32'(din_viol - dv0), 0);
      if (vecs[i].len != 0)
        check({p, "_pattern"}, 32'(pattern_mismatches(int'(vecs[i].len), vecs[i].seed, vecs[i].mode)), 0);
      if (i == 1) begin
        check("lfsr_w0", 32'(mem[0]), 32'h0000ACE1);
        check("lfsr_w1", 32'(mem[1]), 32'h00005670);
        check("lfsr_w2", 32'(mem[2]), 32'h0000AB38);
      end
      @(negedge clk_rw);
      check({p, "_done_pulse"}, 32'(done), 0);
      check({p, "_pass_hold"},  32'(pass), 32'(vecs[i].exp_pass));
    end
    stall_at = -1; stall_len = 0; toggle_empty = 1'b0; cor_a = -1; cor_b = -1;

    // start while busy must not restart or relatch
    w0 = tot_writes; wl0 = wr_loads;
    launch(24'h000300, 24'd64, 16'h5555, 1'b0);
    repeat (4) @(negedge clk_rw);
    base_addr = 24'h000777; length = 24'd3; seed = 16'h0000; start = 1'b1;
    @(negedge clk_rw);
    start = 1'b0;
    check("busy_start_wr_addr",   32'(bus.wr_addr), 32'h300);
    check("busy_start_wr_length", 32'(bus.wr_length), 32'd64);
    wait_done("busy_start");
    check("busy_start_pass",     32'(pass), 1);
    check("busy_start_rd_addr",  32'(bus.rd_addr), 32'h300);
    check("busy_start_writes",   32'(tot_writes - w0), 32'd64);
    check("busy_start_wr_loads", 32'(wr_loads - wl0), 1);
    check("busy_start_pattern",  32'(pattern_mismatches(64, 16'h5555, 1'b0)), 0);

    // asynchronous reset in the middle of RD_DATA
    launch(24'h000400, 24'd64, 16'hBEEF, 1'b1);
    begin
      int n;
      n = 0;
      while (!bus.rd_req && (n < 1000)) begin
        @(negedge clk_rw);
        #2;
        n++;
      end
      check("midrst_reached_rd", 32'(bus.rd_req), 1);
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk_rw);
    rst_n = 1'b1;
    @(negedge clk_rw);
    w0 = tot_writes; r0 = tot_reads;
    launch(24'h000040, 24'd64, 16'h0007, 1'b1);
    wait_done("post_rst");
    check("post_rst_pass",    32'(pass), 1);
    check("post_rst_err_cnt", 32'(err_cnt), 0);
    check("post_rst_writes",  32'(tot_writes - w0), 32'd64);
    check("post_rst_reads",   32'(tot_reads - r0), 32'd64);

    repeat (2) @(negedge clk_rw);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_traffic_master.md
# sdram_traffic_master

Synthesizable host-side initiator for the `sdram_mcb` user interface, in the `clk_rw` domain. On `start` it writes a generated data pattern of `length` words from `base_addr` through the write port, waits for `wr_done`, reads the same range back through the read port and compares every word. It reports pass/fail, an error count and the first failing address. It is the on-board replacement for the simulation host, used for hardware bring-up and soak tests of the SDRAM controller.

## Interface
Parameters:
- `ERR_W`, 16: width of `err_cnt`; the counter saturates at all-ones.

Ports:
- `clk_rw`  in  1  user-side clock, same clock as `sdram_mcb.clk_rw`.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `base_addr`  in  24  start address, {Bank[1:0], Row[12:0], Col[8:0]}; latched on `start`.
- `length`  in  24  number of words to transfer (not 0's based); latched on `start`.
- `seed`  in  16  pattern seed; latched on `start`.
- `mode`  in  1  0 = incrementing pattern, 1 = LFSR pattern; latched on `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  valid from `done` until the next accepted `start`; 1 when `err_cnt == 0`.
- `err_cnt`  out  ERR_W  number of miscompares; saturating.
- `first_err_addr`  out  24  `base_addr + i` of the first miscompare; 0 if there are none.
- `wr_load`, `wr_addr[23:0]`, `wr_length[23:0]`, `wr_req`, `din[15:0]`  out  write port to `sdram_mcb`.
- `wr_done`, `wr_rdy`  in  1  write completion and write-FIFO ready from `sdram_mcb`.
- `rd_load`, `rd_addr[23:0]`, `rd_length[23:0]`, `rd_req`  out  read port to `sdram_mcb`.
- `dout`  in  16  read data; valid in the cycle after `rd_req`.
- `rd_done`, `rd_fifo_empty`  in  1  read completion and read-FIFO empty from `sdram_mcb`.

## Operation
- Pattern word i:
  - mode 0: `seed + i`, wrapping modulo 2^16.
  - mode 1: word 0 = `seed`, or 16'h0001 if `seed == 0`. Each following word is one Fibonacci LFSR step, taps x^16+x^14+x^13+x^11+1.
  - Separate write and read generators, both reloaded from the latched seed.
- States:
  - IDLE: all strobes low. On `start`: latch the inputs, clear `err_cnt`, `first_err_addr` and `pass`. If `length == 0`, go to DONE. Otherwise go to WR_LOAD.
  - WR_LOAD: `wr_load = 1` for exactly one cycle, with `wr_addr`/`wr_length` equal to the latched values; these outputs hold their values through the run. Next state WR_DATA.
  - WR_DATA: `wr_req = wr_rdy && wr_cnt < length`.
    - `din` carries the current write-pattern word in the same cycle.
    - The write generator and `wr_cnt` advance only when `wr_req = 1`.
    - Go to WR_WAIT when `wr_cnt == length`.
  - WR_WAIT: wait for `wr_done`, then go to RD_LOAD.
  - RD_LOAD: `rd_load = 1` for exactly one cycle, with `rd_addr`/`rd_length` equal to the latched values. Next state RD_DATA.
  - RD_DATA: `rd_req = !rd_fifo_empty && req_cnt < length`. `rd_req_d` is `rd_req` delayed by one cycle.
    - When `rd_req_d = 1`: compare `dout` with the read-pattern word, advance the read generator, increment `chk_cnt`.
    - On a miscompare: increment `err_cnt` (saturating). If this is the first miscompare, load `first_err_addr` with `base_addr + chk_cnt` (24-bit wrap).
    - Go to DONE when `chk_cnt == length`.
  - DONE: `done = 1` for one cycle, `pass = (err_cnt == 0)`, `busy = 0`. Return to IDLE.
- `start` while busy is ignored.
- `rd_done` is informational only and is not used for sequencing.
- Counters are 24 bits. Address arithmetic wraps at 2^24.

## Timing
- Reset values: `busy`, `done`, `pass`, `wr_load`, `wr_req`, `rd_load`, `rd_req` = 0. `err_cnt`, `first_err_addr`, `wr_addr`, `wr_length`, `rd_addr`, `rd_length`, `din` = 0. State = IDLE.
- `start` at cycle t: `busy = 1` and `wr_load = 1` at t+1, first possible `wr_req` at t+2.
- Zero length: `done` at t+1, `pass = 1`, no `wr_load` or `rd_load`.
- With `wr_rdy` held high, `wr_req` is high for exactly `length` consecutive cycles. When `wr_rdy` drops, `wr_req` drops in the same cycle and `din` holds.
- `rd_req` drops in the same cycle `rd_fifo_empty` rises; this is a combinational term of the registered state and counters. Data for a given `rd_req` is checked exactly one cycle later.
- The final compare occurs at cycle c; `done` is asserted at c+1.
- Reset asserted mid-run: the block returns to IDLE immediately and all outputs take their reset values. The controller must also be reset; no recovery of a partial transfer is attempted.

## Test plan
- `sdram_mcb` plus SDRAM model, `base_addr` 0x1F0, `length` 1024, mode 0, `seed` 0 → `done` with `pass = 1`, `err_cnt = 0`; words 0x0000..0x03FF are written.
- `base_addr` 0x1F1, `length` 0x100, mode 1, `seed` 0xACE1 (crosses a column boundary) → `pass = 1`. The first three `din` values are 0xACE1 followed by two correct LFSR steps, checked against a bench model.
- Behavioural mock port that corrupts read word 5 of 16 and word 9, `base_addr` 0x100 → `err_cnt = 2`, `first_err_addr = 0x105`, `pass = 0`.
- Mock holds `wr_rdy` low for 10 cycles mid-burst, and toggles `rd_fifo_empty` every other cycle → exactly `length` `wr_req` pulses and `length` compares, `pass = 1`, `din` stable during stalls.
- `length = 0` → `done` one cycle after `start`, `wr_load` and `rd_load` never asserted, `pass = 1`. A `start` pulse while busy → no restart and the latched parameters are unchanged.
- Assert `rst_n` low during RD_DATA → all outputs return to reset values within the same cycle (asynchronous). A subsequent `length` = 64 run completes with `pass = 1`.
